// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Package    : fb_pkg
// Description: Shared sizes, pixel type, command opcodes and writer states
//              for the frame-buffer write engine.
// Revision   : 1.0
// ============================================================================
package fb_pkg;

   localparam int FB_DIM  = 256;
   localparam int COLOR_W = 12;
   localparam int XY_W    = 8;
   localparam int ADDR_W  = 2*XY_W + 1;
   localparam int CNT_W   = 2*XY_W;
   localparam int DATA_W  = 3*COLOR_W;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } pixel_t;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_CLEAR = 2'b01,
      OP_SWAP  = 2'b10,
      OP_RSVD  = 2'b11
   } fb_op_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR     = 2'd1,
      SWAP_WAIT = 2'd2
   } fb_state_e;

   // RAM word address: buffer select above row above column.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic sel,
                                                  input logic [XY_W-1:0] y,
                                                  input logic [XY_W-1:0] x);
      return {sel, y, x};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_writer_if.sv
`default_nettype none
// ============================================================================
// Interface  : fb_writer_if
// Description: CPU command channel (valid/ready) into the frame-buffer writer.
// Revision   : 1.0
// ============================================================================
interface fb_writer_if;
   import fb_pkg::*;

   logic             iCMD_VALID;
   logic             oCMD_READY;
   fb_op_e           iCMD_OP;
   logic [XY_W-1:0]  iCMD_X;
   logic [XY_W-1:0]  iCMD_Y;
   pixel_t           iCMD_RGB;

   modport master (
      output iCMD_VALID, iCMD_OP, iCMD_X, iCMD_Y, iCMD_RGB,
      input  oCMD_READY
   );

   modport slave (
      input  iCMD_VALID, iCMD_OP, iCMD_X, iCMD_Y, iCMD_RGB,
      output oCMD_READY
   );

endinterface
`default_nettype wire

// File: rtl/fb_writer_sync_fall_det.sv
`default_nettype none
// ============================================================================
// Module     : sync_fall_det
// Description: Falling-edge detector on a signal already in the clk domain.
// Revision   : 1.0
// ============================================================================
module sync_fall_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic fall_o
);

   logic sig_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   // Same-cycle indication so the consumer can act on the edge that follows.
   assign fall_o = sig_q & ~sig_i;

endmodule
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// Module     : fb_writer
// Description: Write engine for the double-buffered 256x256 frame RAM:
//              pixel writes, full-buffer clears, vsync-aligned buffer swaps.
// Revision   : 1.0
// ============================================================================
module fb_writer
   import fb_pkg::*;
(
   input  logic              iCLK,
   input  logic              iRST,
   fb_writer_if.slave        cmd,
   input  logic              iVGA_V_SYNC,
   output logic              oWR_EN,
   output logic [ADDR_W-1:0] oWR_ADDR,
   output logic [DATA_W-1:0] oWR_DATA,
   output logic              oFRONT_SEL,
   output logic              oBUSY,
   output logic              oSWAP_DONE
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fb_state_e         state_q;
   logic              ready_q;
   logic              busy_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              front_q;
   logic              swap_done_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              accept_d;
   logic              back_d;
   logic              vs_fall;

   sync_fall_det u_vs_fall (
      .clk_i  (iCLK),
      .rst_i  (iRST),
      .sig_i  (iVGA_V_SYNC),
      .fall_o (vs_fall)
   );

   always_comb begin
      accept_d = cmd.iCMD_VALID & ready_q;
      back_d   = ~front_q;
      cnt_d    = cnt_q + 1'b1;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         front_q     <= 1'b0;
         swap_done_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         wr_en_q     <= 1'b0;
         swap_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               if (accept_d) begin
                  unique case (cmd.iCMD_OP)
                     OP_WRITE: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= fb_addr(back_d, cmd.iCMD_Y, cmd.iCMD_X);
                        wr_data_q <= cmd.iCMD_RGB;
                     end
                     OP_CLEAR: begin
                        state_q   <= CLEAR;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        wr_en_q   <= 1'b1;
                        cnt_q     <= '0;
                        wr_addr_q <= {back_d, {CNT_W{1'b0}}};
                        wr_data_q <= cmd.iCMD_RGB;
                     end
                     OP_SWAP: begin
                        state_q <= SWAP_WAIT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            CLEAR: begin
               // Buffer select and fill colour stay frozen in the write registers.
               if (cnt_q == CNT_MAX) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q     <= cnt_d;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= {wr_addr_q[ADDR_W-1], cnt_d};
               end
            end
            SWAP_WAIT: begin
               if (vs_fall) begin
                  front_q     <= ~front_q;
                  swap_done_q <= 1'b1;
                  state_q     <= IDLE;
                  ready_q     <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd.oCMD_READY = ready_q;
   assign oWR_EN         = wr_en_q;
   assign oWR_ADDR       = wr_addr_q;
   assign oWR_DATA       = wr_data_q;
   assign oFRONT_SEL     = front_q;
   assign oBUSY          = busy_q;
   assign oSWAP_DONE     = swap_done_q;

endmodule
`default_nettype wire

// File: doc/fb_writer.md
Name: fb_writer

Overview:
Write-side engine for the 256x256 RGB frame buffer that the VGA timing block scans out. It accepts pixel-write, clear and buffer-swap commands from the game CPU over a valid/ready handshake, then drives the write port of a double-buffered dual-port frame RAM. Buffer swaps take effect only on a vertical-sync falling edge, so the display never shows a partially drawn frame.

Parameters:
FB_DIM, 256, frame buffer side length in pixels; must be a power of two.
COLOR_W, 12, bits per colour channel.
XY_W, 8, coordinate width, equal to log2(FB_DIM).

Ports:
iCLK  in  1  system/pixel clock
iRST  in  1  reset, synchronous, active-high
iCMD_VALID  in  1  command valid
oCMD_READY  out  1  engine can accept a command this cycle
iCMD_OP  in  2  00=WRITE, 01=CLEAR, 10=SWAP, 11=reserved
iCMD_X  in  XY_W  pixel column (WRITE)
iCMD_Y  in  XY_W  pixel row (WRITE)
iCMD_RGB  in  3*COLOR_W  {R,G,B} pixel colour (WRITE), or fill colour (CLEAR)
iVGA_V_SYNC  in  1  active-low vsync from the timing generator, already in the iCLK domain
oWR_EN  out  1  RAM write strobe
oWR_ADDR  out  2*XY_W+1  {buffer_sel, y, x}
oWR_DATA  out  3*COLOR_W  RAM write data
oFRONT_SEL  out  1  buffer index the display reads
oBUSY  out  1  high whenever state is not IDLE
oSWAP_DONE  out  1  one-cycle pulse when a swap takes effect

Behaviour:
- Clocking and reset: one clock, iCLK; iRST is synchronous and active-high.
- Reset values: every output is 0, state=IDLE, clear counter=0, vs_q=0. oCMD_READY is 1 from the first cycle after reset is released.
- The back buffer is ~oFRONT_SEL. Every write targets the back buffer.
- Handshake: a command is accepted when iCMD_VALID & oCMD_READY are both high. oCMD_READY = (state==IDLE). It is registered-consistent: it never depends combinationally on iCMD_VALID.
- All RAM outputs (oWR_EN, oWR_ADDR, oWR_DATA) are registered.
- WRITE, accepted in cycle T:
  - In cycle T+1: oWR_EN=1, oWR_ADDR={back, Y, X}, oWR_DATA=RGB.
  - State stays IDLE, so back-to-back WRITEs sustain one pixel per cycle.
- CLEAR, accepted in cycle T:
  - Enters CLEAR and latches the fill colour.
  - Cycles T+1..T+FB_DIM^2: oWR_EN=1, oWR_ADDR={back, cnt}, with cnt running 0..FB_DIM^2-1.
  - The last write (cnt=65535 at default) also returns the state to IDLE, so oCMD_READY=1 in cycle T+FB_DIM^2+1.
  - The back-buffer select is latched at accept and cannot change during CLEAR.
- SWAP, accepted in cycle T:
  - Enters SWAP_WAIT.
  - fall = vs_q & ~iVGA_V_SYNC, with vs_q <= iVGA_V_SYNC every cycle.
  - On the first fall detected in a cycle > T: oFRONT_SEL toggles (visible on the next edge), oSWAP_DONE pulses for exactly one cycle, and the state returns to IDLE.
  - A fall in cycle T itself is ignored.
- Reserved op 11: accepted, no RAM write, state stays IDLE.
- oWR_EN=0 in every cycle not listed above.
- Reset mid-CLEAR or mid-SWAP_WAIT: the operation is aborted immediately, no further writes occur, and oFRONT_SEL returns to 0.
- Width rules: X and Y are exactly XY_W bits, so out-of-range addressing is impossible. The address is a concatenation, not arithmetic.
- States: IDLE -> CLEAR (op 01), IDLE -> SWAP_WAIT (op 10), CLEAR -> IDLE (cnt==max), SWAP_WAIT -> IDLE (fall).

Decomposition:
- Package fb_pkg holds:
  - FB_DIM, COLOR_W, XY_W
  - typedef pixel_t, a packed struct {r, g, b} of COLOR_W bits each
  - enum fb_op_e {OP_WRITE, OP_CLEAR, OP_SWAP, OP_RSVD}
  - enum fb_state_e {IDLE, CLEAR, SWAP_WAIT}
- Sub-module sync_fall_det: registered falling-edge detector, reused later for hsync-based events.
- The frame RAM is instantiated outside this block.

Test Plan:
1. Reset released, WRITE x=100 y=200 rgb=36'hFFF_000_FFF accepted at T -> at T+1 oWR_EN=1, oWR_ADDR=17'h1_C864, oWR_DATA=36'hFFF000FFF.
2. Three back-to-back WRITEs with valid held high -> oCMD_READY stays 1, and three consecutive oWR_EN cycles occur with the matching addresses.
3. CLEAR rgb=0 at T -> 65536 writes, addresses 17'h1_0000..17'h1_FFFF; oCMD_READY=0 throughout and returns to 1 at T+65537. A WRITE presented during CLEAR is not accepted.
4. SWAP accepted while vsync is high, vsync driven low 40 cycles later -> oSWAP_DONE pulses once, oFRONT_SEL 0->1, and the next WRITE uses addr bit16=0.
5. SWAP accepted in the same cycle as a vsync fall -> no swap on that fall; the swap occurs on the following fall.
6. iRST asserted at cnt=1000 during CLEAR -> oWR_EN=0 from the next cycle, all outputs are 0 and oFRONT_SEL=0, and oCMD_READY=1 after release.
